uart_tx_arbiter: RTL and testbench

Round-robin arbiter and frame sequencer that shares one UART transmitter between NUM_REQ byte sources. It selects a requester, launches one frame into the UART TX (data, data-valid pulse, per-frame parity enable), then tracks the transmitter's busy flag until the frame completes before granting again. It sits directly in front of the UART TX top, between the system-side byte producers and the transmitter's P_DATA/data_valid/par_en inputs.

---
 rtl/uart_tx_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between NUM_REQ byte sources: picks a requester, launches one frame, tracks tx_busy.
// Define UART_ARB_RR_EN for round-robin selection; otherwise fixed priority (lowest index wins).
module uart_tx_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int DATA_W   = 8,
  parameter int BUSY_TMO = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_par_en,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [DATA_W-1:0]         tx_data,
  output logic                      tx_valid,
  output logic                      tx_par_en,
  input  logic                      tx_busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                      active,
  output logic                      tmo_err
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(BUSY_TMO + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT_BUSY,
    S_WAIT_DONE
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic                w_launch;
  logic                w_tmo;
  logic                w_done;

  logic                w_win_found;
  logic [ID_W-1:0]     w_win_id;
  logic [DATA_W-1:0]   w_win_data;
  logic                w_win_par;

  logic [NUM_REQ-1:0]  r_req_ready;
  logic [DATA_W-1:0]   r_tx_data;
  logic                r_tx_valid;
  logic                r_tx_par_en;
  logic [ID_W-1:0]     r_grant_id;
  logic                r_active;
  logic                r_tmo_err;

`ifdef UART_ARB_RR_EN
  logic [ID_W-1:0]     r_last_grant;

  // Scan from farthest to nearest after the pointer so the nearest valid requester wins.
  always_comb begin : p_sel
    int idx;
    idx         = 0;
    w_win_found = 1'b0;
    w_win_id    = '0;
    w_win_data  = '0;
    w_win_par   = 1'b0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = (int'(r_last_grant) + k) % NUM_REQ;
      if (req_valid[idx]) begin
        w_win_found = 1'b1;
        w_win_id    = ID_W'(idx);
        w_win_data  = req_data[idx*DATA_W +: DATA_W];
        w_win_par   = req_par_en[idx];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last_grant <= ID_W'(NUM_REQ - 1);
    end else if (r_state == S_LAUNCH) begin
      r_last_grant <= r_grant_id;
    end
  end
`else
  always_comb begin : p_sel
    w_win_found = 1'b0;
    w_win_id    = '0;
    w_win_data  = '0;
    w_win_par   = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_valid[k]) begin
        w_win_found = 1'b1;
        w_win_id    = ID_W'(k);
        w_win_data  = req_data[k*DATA_W +: DATA_W];
        w_win_par   = req_par_en[k];
      end
    end
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_launch    = 1'b0;
    w_tmo       = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_win_found) begin
          w_launch    = 1'b1;
          w_state_nxt = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        w_cnt_nxt   = '0;
        w_state_nxt = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        w_cnt_nxt = r_cnt + 1'b1;
        // A busy rise on the timeout cycle still counts as a started frame.
        if (tx_busy) begin
          w_state_nxt = S_WAIT_DONE;
        end else if (w_cnt_nxt == CNT_W'(BUSY_TMO)) begin
          w_tmo       = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      S_WAIT_DONE: begin
        if (!tx_busy) begin
          w_done      = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs are registered on the transition into LAUNCH so they line up with that state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_req_ready <= '0;
      r_tx_data   <= '0;
      r_tx_valid  <= 1'b0;
      r_tx_par_en <= 1'b0;
      r_grant_id  <= '0;
      r_active    <= 1'b0;
      r_tmo_err   <= 1'b0;
    end else begin
      r_tx_valid  <= w_launch;
      r_req_ready <= w_launch ? (NUM_REQ'(1) << w_win_id) : '0;
      r_tmo_err   <= w_tmo;
      if (w_launch) begin
        r_tx_data   <= w_win_data;
        r_tx_par_en <= w_win_par;
        r_grant_id  <= w_win_id;
        r_active    <= 1'b1;
      end else if (w_tmo || w_done) begin
        r_active    <= 1'b0;
      end
    end
  end

  assign req_ready = r_req_ready;
  assign tx_data   = r_tx_data;
  assign tx_valid  = r_tx_valid;
  assign tx_par_en = r_tx_par_en;
  assign grant_id  = r_grant_id;
  assign active    = r_active;
  assign tmo_err   = r_tmo_err;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: request queues per source, a UART busy model and a launch monitor.
module tb_uart_tx_arbiter;
  localparam int NUM_REQ  = 4;
  localparam int DATA_W   = 8;
  localparam int BUSY_TMO = 4;
  localparam int ID_W     = $clog2(NUM_REQ);

  logic                      clk;
  logic                      rst;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_par_en;
  logic [NUM_REQ-1:0]        req_ready;
  logic [DATA_W-1:0]         tx_data;
  logic                      tx_valid;
  logic                      tx_par_en;
  logic                      tx_busy;
  logic [ID_W-1:0]           grant_id;
  logic                      active;
  logic                      tmo_err;

  uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .BUSY_TMO(BUSY_TMO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_par_en(req_par_en), .req_ready(req_ready), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_par_en(tx_par_en), .tx_busy(tx_busy),
    .grant_id(grant_id), .active(active), .tmo_err(tmo_err)
  );

  typedef struct packed { logic [DATA_W-1:0] data; logic par; } byte_t;
  typedef struct packed { logic [ID_W-1:0] id; logic [DATA_W-1:0] data; logic par; } exp_t;

  byte_t rq [NUM_REQ][$];
  exp_t  exp_q[$];
  int    n_chk = 0;
  int    n_fail = 0;
  int    model_last = NUM_REQ - 1;
  bit    tie_low = 0;
  int    cyc = 0;

  logic  m_busy_q;
  logic  m_txv_q;
  int    m_idle_cnt;
  bit    m_armed;
  int    m_tmo_due;
  int    u_dly;
  int    u_len;
  logic  u_txv;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference selection: next pending requester after the previous winner, or lowest pending one.
  function automatic int pick(input bit [NUM_REQ-1:0] pend, input int last);
`ifdef UART_ARB_RR_EN
    for (int k = 1; k <= NUM_REQ; k++)
      if (pend[(last + k) % NUM_REQ]) return (last + k) % NUM_REQ;
`else
    for (int k = 0; k < NUM_REQ; k++)
      if (pend[k]) return k;
    if (last < 0) return -2;
`endif
    return -1;
  endfunction

  task automatic build_expected();
    int pos[NUM_REQ];
    int w;
    bit [NUM_REQ-1:0] pend;
    exp_t e;
    for (int i = 0; i < NUM_REQ; i++) pos[i] = 0;
    forever begin
      for (int i = 0; i < NUM_REQ; i++) pend[i] = (pos[i] < rq[i].size());
      w = pick(pend, model_last);
      if (w < 0) break;
      e.id   = ID_W'(w);
      e.data = rq[w][pos[w]].data;
      e.par  = rq[w][pos[w]].par;
      exp_q.push_back(e);
      pos[w]++;
      model_last = w;
    end
  endtask

  function automatic bit all_rq_empty();
    for (int i = 0; i < NUM_REQ; i++)
      if (rq[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !all_rq_empty() || active || tx_busy) && n < 2000) begin
      @(posedge clk);
      n++;
    end
    if (n >= 2000) begin
      n_chk++;
      n_fail++;
      $display("FAIL round_timeout %s: pending_expected=%0d required 0", tag, exp_q.size());
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic push_req(input int i, input logic [DATA_W-1:0] d, input logic p);
    byte_t b;
    b.data = d;
    b.par  = p;
    rq[i].push_back(b);
  endtask

  task automatic check_reset_zero(input string tag);
    check({tag, "_tx_valid"},  32'(tx_valid), 0);
    check({tag, "_tx_data"},   32'(tx_data), 0);
    check({tag, "_tx_par_en"}, 32'(tx_par_en), 0);
    check({tag, "_req_ready"}, 32'(req_ready), 0);
    check({tag, "_grant_id"},  32'(grant_id), 0);
    check({tag, "_active"},    32'(active), 0);
    check({tag, "_tmo_err"},   32'(tmo_err), 0);
  endtask

  task automatic reset_mid_frame(input string tag, input bit add0);
    int n;
    n = 0;
    while (!tx_busy && n < 200) begin
      @(posedge clk);
      n++;
    end
    if (n >= 200) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s_busy_wait: tx_busy stayed 0, required 1", tag);
    end
    @(posedge clk);
    #2;
    rst = 0;
    #1;
    check_reset_zero(tag);
    exp_q.delete();
    model_last = NUM_REQ - 1;
    if (add0) push_req(0, 8'h3C, 1'b1);
    repeat (2) @(negedge clk);
    rst = 1;
    build_expected();
    wait_idle(tag);
  endtask

  // Requesters: hold the head of each queue valid, pop it on req_ready.
  initial begin
    req_valid  = '0;
    req_data   = '0;
    req_par_en = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < NUM_REQ; i++) begin
        if (rst && req_ready[i] && rq[i].size() > 0) rq[i].delete(0);
        if (rq[i].size() > 0) begin
          req_valid[i]                    = 1'b1;
          req_data[i*DATA_W +: DATA_W]    = rq[i][0].data;
          req_par_en[i]                   = rq[i][0].par;
        end else begin
          req_valid[i] = 1'b0;
        end
      end
    end
  end

  // UART TX model: busy rises 2 cycles after data_valid is sampled, stays up 3..9 cycles.
  initial begin
    tx_busy = 0;
    u_dly   = 0;
    u_len   = 0;
    u_txv   = 0;
    forever begin
      @(negedge clk);
      u_txv = tx_valid;
      @(posedge clk);
      #1;
      if (!rst) begin
        tx_busy = 0;
        u_dly   = 0;
        u_len   = 0;
      end else begin
        if (u_dly > 0) begin
          u_dly--;
          if (u_dly == 0) begin
            tx_busy = 1;
            u_len   = $urandom_range(2, 8);
          end
        end else if (tx_busy) begin
          if (u_len == 0) tx_busy = 0;
          else u_len--;
        end
        if (u_txv && !tie_low) u_dly = 1;
      end
    end
  end

  // Monitor: every launch is popped from the scoreboard and compared.
  initial begin
    exp_t e;
    m_busy_q   = 0;
    m_txv_q    = 0;
    m_idle_cnt = 0;
    m_armed    = 0;
    m_tmo_due  = -1;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst) begin
        m_armed   = 0;
        m_tmo_due = -1;
        m_busy_q  = 0;
        m_txv_q   = 0;
      end else begin
        if (m_busy_q && !tx_busy) begin
          m_armed    = 1;
          m_idle_cnt = 1;
        end else if (m_armed && !tx_valid) begin
          m_idle_cnt++;
          if (m_idle_cnt == 2) check("active_drop_after_frame", 32'(active), 0);
        end
        if (tx_valid) begin
          check("tx_valid_single_cycle", 32'(m_txv_q), 0);
          if (m_armed) check("launch_gap_ge2", 32'(m_idle_cnt >= 2), 1);
          m_armed = 0;
          if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_launch: grant_id=%0d with no expected frame", grant_id);
          end else begin
            e = exp_q.pop_front();
            check("grant_id",  32'(grant_id), 32'(e.id));
            check("tx_data",   32'(tx_data), 32'(e.data));
            check("tx_par_en", 32'(tx_par_en), 32'(e.par));
            check("req_ready", 32'(req_ready), 32'(1) << e.id);
            check("active_at_launch", 32'(active), 1);
          end
          // Pulse expected on the cycle after the counter reaches BUSY_TMO.
          if (tie_low) m_tmo_due = cyc + BUSY_TMO + 1;
        end
        if (tmo_err || cyc == m_tmo_due) begin
          check("tmo_err_timing", 32'(tmo_err), 32'(cyc == m_tmo_due));
          if (tmo_err) check("active_at_tmo", 32'(active), 0);
        end
        if (tx_busy) check("active_in_frame", 32'(active), 1);
        m_busy_q = tx_busy;
        m_txv_q  = tx_valid;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int mask;
    rst = 0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_zero("reset");
    @(negedge clk);
    rst = 1;

    for (int i = 0; i < NUM_REQ; i++)
      for (int j = 0; j < 2; j++)
        push_req(i, DATA_W'(8'h10 + i * 16 + j), 1'($urandom));
    build_expected();
    wait_idle("all_four");

    push_req(2, 8'hA5, 1'b1);
    build_expected();
    wait_idle("single");

    for (int r = 0; r < 10; r++) begin
      mask = $urandom_range(1, (1 << NUM_REQ) - 1);
      for (int i = 0; i < NUM_REQ; i++)
        if (mask[i])
          for (int j = 0; j < int'($urandom_range(1, 3)); j++)
            push_req(i, DATA_W'($urandom), 1'($urandom));
      build_expected();
      wait_idle("random");
    end

    tie_low = 1;
    push_req(1, 8'h5A, 1'b0);
    build_expected();
    wait_idle("timeout");
    tie_low = 0;
    push_req(1, 8'hC3, 1'b1);
    build_expected();
    wait_idle("after_timeout");

    push_req(3, 8'h71, 1'b0);
    push_req(3, 8'h72, 1'b1);
    build_expected();
    reset_mid_frame("rst_a", 1'b0);

    push_req(3, 8'h81, 1'b1);
    push_req(3, 8'h82, 1'b0);
    build_expected();
    reset_mid_frame("rst_b", 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
